// File: rtl/vlog_arb_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
package vlog_arb_pkg;

   // One-hot state encoding; anything else is treated as corrupt.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b01,
      ST_GRANT = 2'b10
   } state_e;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_MAX_HOLD = 8;

   // Index width for n requesters, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Counter width able to hold the value m (one bit when m is zero).
   function automatic int hold_width(input int m);
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/vlog_rr_pick.sv
// Rotating-priority search: first set request at or after ptr, wrapping.
module vlog_rr_pick
   import vlog_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int CW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [CW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic [CW-1:0]   pick_idx,
   output logic            any
);

   // Two passes: indices ptr..NREQ-1 first, then 0..ptr-1.
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      any      = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req[k] && (CW'(k) >= ptr)) begin
            any      = 1'b1;
            pick[k]  = 1'b1;
            pick_idx = CW'(k);
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req[k] && (CW'(k) < ptr)) begin
            any      = 1'b1;
            pick[k]  = 1'b1;
            pick_idx = CW'(k);
         end
      end
   end

endmodule

// File: rtl/vlog_rr_arbiter.sv
// Round-robin arbiter with bounded hold, lock override and an idle gap
// between owners. All outputs come straight from flops.
module vlog_rr_arbiter
   import vlog_arb_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req,
   input  logic                        lock,
   output logic [NREQ-1:0]             gnt,
   output logic [idx_width(NREQ)-1:0]  gnt_id,
   output logic                        busy
);

   localparam int CW = idx_width(NREQ);
   localparam int HW = hold_width(MAX_HOLD);

   localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
   localparam logic [CW-1:0] LAST_IDX  = CW'(NREQ - 1);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [CW-1:0]   gnt_id_q, gnt_id_d;
   logic            busy_q, busy_d;
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;

   logic [NREQ-1:0] pick;
   logic [CW-1:0]   pick_idx;
   logic            pick_any;
   logic            owner_req;
   logic            others_pending;
   logic            preempt;

   vlog_rr_pick #(
      .NREQ (NREQ),
      .CW   (CW)
   ) u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx),
      .any      (pick_any)
   );

   // Release conditions: owner drops its request, or its time slice is up
   // while someone else waits and the owner is not holding lock.
   always_comb begin
      owner_req      = |(req & gnt_q);
      others_pending = |(req & ~gnt_q);
      preempt        = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST) && !lock && others_pending;
   end

   // Next-state logic: grant from IDLE, count/release in GRANT.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      hold_d   = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d  = ST_GRANT;
               gnt_d    = pick;
               gnt_id_d = pick_idx;
               busy_d   = 1'b1;
               hold_d   = '0;
            end
         end
         ST_GRANT: begin
            if (!owner_req || preempt) begin
               state_d  = ST_IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
               hold_d   = '0;
               ptr_d    = (gnt_id_q == LAST_IDX) ? '0 : (gnt_id_q + CW'(1));
            end else if (hold_q != HOLD_SAT) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
            hold_d   = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_vlog_rr_arbiter.sv
// Directed bench for vlog_rr_arbiter: a 4-requester instance (MAX_HOLD 8)
// and a 3-requester instance (MAX_HOLD 4) sharing clock and reset.
module tb_vlog_rr_arbiter;

   logic       clock;
   logic       reset;
   logic [3:0] req_a;
   logic       lock_a;
   logic [3:0] gnt_a;
   logic [1:0] gnt_id_a;
   logic       busy_a;
   logic [2:0] req_b;
   logic       lock_b;
   logic [2:0] gnt_b;
   logic [1:0] gnt_id_b;
   logic       busy_b;

   int total = 0;
   int bad   = 0;
   logic chk_on = 1'b0;

   vlog_rr_arbiter #(.NREQ(4), .MAX_HOLD(8)) dut_a (
      .clock  (clock),
      .reset  (reset),
      .req    (req_a),
      .lock   (lock_a),
      .gnt    (gnt_a),
      .gnt_id (gnt_id_a),
      .busy   (busy_a)
   );

   vlog_rr_arbiter #(.NREQ(3), .MAX_HOLD(4)) dut_b (
      .clock  (clock),
      .reset  (reset),
      .req    (req_b),
      .lock   (lock_b),
      .gnt    (gnt_b),
      .gnt_id (gnt_id_b),
      .busy   (busy_b)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Count a comparison and report it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] ra, input logic la, input logic [2:0] rb);
      req_a  = ra;
      lock_a = la;
      req_b  = rb;
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [1:0] oh_index(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
      return r;
   endfunction

   task automatic expectA(input string tag, input logic [3:0] exp_gnt);
      checkOutput({tag, ".gnt_a"},    32'(gnt_a),    32'(exp_gnt));
      checkOutput({tag, ".gnt_id_a"}, 32'(gnt_id_a), 32'(oh_index(exp_gnt)));
      checkOutput({tag, ".busy_a"},   32'(busy_a),   32'(|exp_gnt));
   endtask

   task automatic expectB(input string tag, input logic [2:0] exp_gnt);
      checkOutput({tag, ".gnt_b"},    32'(gnt_b),    32'(exp_gnt));
      checkOutput({tag, ".gnt_id_b"}, 32'(gnt_id_b), 32'(oh_index({1'b0, exp_gnt})));
      checkOutput({tag, ".busy_b"},   32'(busy_b),   32'(|exp_gnt));
   endtask

   // Every cycle: grants are one-hot or zero, and busy mirrors the grant.
   always @(negedge clock) begin
      if (chk_on) begin
         checkOutput("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
         checkOutput("busy_eq_a", 32'(busy_a), 32'(|gnt_a));
         checkOutput("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
         checkOutput("busy_eq_b", 32'(busy_b), 32'(|gnt_b));
      end
   end

   initial begin
      logic [3:0] exp_a;
      logic [2:0] exp_b;

      lock_b = 1'b0;
      reset  = 1'b0;
      applyStimulus(4'b1111, 1'b0, 3'b111);
      tick();
      tick();
      chk_on = 1'b1;
      expectA("reset", 4'b0000);
      expectB("reset", 3'b000);

      // Single requester 2: one-cycle latency, then release moves ptr to 3.
      applyStimulus(4'b0100, 1'b0, 3'b000);
      reset = 1'b1;
      tick();
      expectA("first_gnt", 4'b0100);
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectA("release2", 4'b0000);
      tick();
      expectA("idle_stays", 4'b0000);
      applyStimulus(4'b1001, 1'b0, 3'b000);
      tick();
      expectA("ptr3", 4'b1000);
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectA("release3", 4'b0000);

      // All requesting from ptr 0: 8-cycle slices with one idle cycle between.
      applyStimulus(4'b1111, 1'b0, 3'b000);
      for (int g = 0; g < 5; g++) begin
         exp_a = 4'b0001 << (g % 4);
         for (int c = 0; c < 8; c++) begin
            tick();
            expectA("rr_slice", exp_a);
         end
         tick();
         expectA("rr_gap", 4'b0000);
      end

      // ptr is now 1: lock keeps owner 1 far past the slice limit.
      applyStimulus(4'b0011, 1'b1, 3'b000);
      tick();
      expectA("lock_start", 4'b0010);
      for (int c = 0; c < 20; c++) begin
         tick();
         expectA("lock_hold", 4'b0010);
      end
      applyStimulus(4'b0011, 1'b0, 3'b000);
      tick();
      expectA("unlock_gap", 4'b0000);
      tick();
      expectA("unlock_next", 4'b0001);
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectA("unlock_rel", 4'b0000);

      // Lone requester 3 is never preempted; its release wraps ptr to 0.
      applyStimulus(4'b1000, 1'b0, 3'b000);
      tick();
      expectA("solo_start", 4'b1000);
      for (int c = 0; c < 30; c++) begin
         tick();
         expectA("solo_hold", 4'b1000);
      end
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectA("solo_rel", 4'b0000);
      applyStimulus(4'b0011, 1'b0, 3'b000);
      tick();
      expectA("ptr_wrap", 4'b0001);
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectA("wrap_rel", 4'b0000);

      // Owner 2 ignores other bits changing, then reset clears it mid-grant.
      applyStimulus(4'b0100, 1'b0, 3'b000);
      tick();
      expectA("own2", 4'b0100);
      applyStimulus(4'b0101, 1'b0, 3'b000);
      tick();
      expectA("own2_stable", 4'b0100);
      applyStimulus(4'b1100, 1'b0, 3'b000);
      tick();
      expectA("own2_stable", 4'b0100);
      applyStimulus(4'b0110, 1'b0, 3'b000);
      tick();
      expectA("own2_stable", 4'b0100);
      reset = 1'b0;
      tick();
      expectA("rst_mid", 4'b0000);
      tick();
      expectA("rst_ignore", 4'b0000);
      reset = 1'b1;
      tick();
      expectA("post_rst", 4'b0010);
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectA("post_rst_rel", 4'b0000);

      // Three requesters: requester 2 releasing wraps ptr to 0.
      applyStimulus(4'b0000, 1'b0, 3'b100);
      tick();
      expectB("b_own2", 3'b100);
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectB("b_rel2", 3'b000);
      applyStimulus(4'b0000, 1'b0, 3'b011);
      tick();
      expectB("b_ptr0", 3'b001);
      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      expectB("b_rel0", 3'b000);

      // ptr is 1: all three requesting give 1,2,0,1 in 4-cycle slices.
      applyStimulus(4'b0000, 1'b0, 3'b111);
      for (int g = 0; g < 4; g++) begin
         exp_b = 3'b001 << ((g + 1) % 3);
         for (int c = 0; c < 4; c++) begin
            tick();
            expectB("b_slice", exp_b);
         end
         tick();
         expectB("b_gap", 3'b000);
      end

      applyStimulus(4'b0000, 1'b0, 3'b000);
      tick();
      tick();
      expectA("end_a", 4'b0000);
      expectB("end_b", 3'b000);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
